// File: rtl/dit_ifft_8.sv
// 8-point radix-2 DIT inverse FFT on Q4.12 complex samples: halves every stage, 3-cycle latency, one frame per cycle.
// Build option: define IFFT_ROUND_EN to round each per-stage halving half-up instead of truncating toward -inf.
module dit_ifft_8 #(
  parameter int DW = 16,
  parameter int FB = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] x [0:7][0:1],
  output logic                 out_valid,
  output logic signed [DW-1:0] y [0:7][0:1]
);

  localparam int SW = 18;
  localparam logic signed [SW-1:0] SAT_MAX = SW'(2**(DW-1) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2**(DW-1)));
  localparam logic signed [DW-1:0] ONE     = DW'(1 << FB);
  localparam logic signed [DW-1:0] R707    = DW'(2896);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef struct packed {
    cplx_t a;
    cplx_t b;
  } pair_t;

  // Conjugate twiddles W8^-k for k = 0..3
  function automatic cplx_t tw(input logic [1:0] k);
    cplx_t w;
    w.re = '0;
    w.im = '0;
    case (k)
      2'd0: w.re = ONE;
      2'd1: begin
        w.re = R707;
        w.im = R707;
      end
      2'd2: w.im = ONE;
      default: begin
        w.re = -R707;
        w.im = R707;
      end
    endcase
    return w;
  endfunction

  function automatic logic signed [SW-1:0] mshift(input logic signed [DW-1:0] w,
                                                  input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = w * b;
    return SW'(p >>> FB);
  endfunction

  function automatic logic signed [SW-1:0] sext(input logic signed [DW-1:0] v);
    return SW'(v);
  endfunction

  function automatic logic signed [DW-1:0] halve_sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] h;
`ifdef IFFT_ROUND_EN
    h = (s + SW'(1)) >>> 1;
`else
    h = s >>> 1;
`endif
    if (h > SAT_MAX) begin
      return {1'b0, {(DW-1){1'b1}}};
    end else if (h < SAT_MIN) begin
      return {1'b1, {(DW-1){1'b0}}};
    end
    return h[DW-1:0];
  endfunction

  function automatic pair_t bfly(input cplx_t a, input cplx_t b, input cplx_t w);
    logic signed [SW-1:0] wb_re;
    logic signed [SW-1:0] wb_im;
    pair_t r;
    wb_re  = mshift(w.re, b.re) - mshift(w.im, b.im);
    wb_im  = mshift(w.re, b.im) + mshift(w.im, b.re);
    r.a.re = halve_sat(sext(a.re) + wb_re);
    r.a.im = halve_sat(sext(a.im) + wb_im);
    r.b.re = halve_sat(sext(a.re) - wb_re);
    r.b.im = halve_sat(sext(a.im) - wb_im);
    return r;
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  cplx_t r0_q [8];
  cplx_t r0_d [8];
  cplx_t s1_q [8];
  cplx_t s1_d [8];
  cplx_t s2_q [8];
  cplx_t s2_d [8];
  cplx_t y_q  [8];
  cplx_t y_d  [8];
  logic  v0_q;
  logic  v1_q;
  logic  v2_q;
  logic  out_valid_q;

  // Input rank: bit-reversed capture, only on accepted frames
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      r0_d[k] = r0_q[k];
      if (in_valid) begin
        r0_d[k].re = x[bitrev3(3'(k))][0];
        r0_d[k].im = x[bitrev3(3'(k))][1];
      end
    end
  end

  // Butterfly stages of span 1, 2 and 4; the last one loads y only with a valid frame
  always_comb begin
    pair_t p;
    p = '0;
    for (int g = 0; g < 4; g++) begin
      p             = bfly(r0_q[2*g], r0_q[2*g+1], tw(2'd0));
      s1_d[2*g]     = p.a;
      s1_d[2*g+1]   = p.b;
    end
    for (int g = 0; g < 2; g++) begin
      for (int j = 0; j < 2; j++) begin
        p               = bfly(s1_q[4*g+j], s1_q[4*g+j+2], tw(2'(2*j)));
        s2_d[4*g+j]     = p.a;
        s2_d[4*g+j+2]   = p.b;
      end
    end
    for (int j = 0; j < 4; j++) begin
      p         = bfly(s2_q[j], s2_q[j+4], tw(2'(j)));
      y_d[j]    = y_q[j];
      y_d[j+4]  = y_q[j+4];
      if (v2_q) begin
        y_d[j]   = p.a;
        y_d[j+4] = p.b;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        r0_q[k] <= '0;
        s1_q[k] <= '0;
        s2_q[k] <= '0;
        y_q[k]  <= '0;
      end
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      r0_q        <= r0_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      y_q         <= y_d;
      v0_q        <= in_valid;
      v1_q        <= v0_q;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
    end
  end

  assign out_valid = out_valid_q;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      y[k][0] = y_q[k].re;
      y[k][1] = y_q[k].im;
    end
  end

endmodule

// File: tb/tb_dit_ifft_8.sv
// Directed bench for dit_ifft_8: reset, impulse/DC/tone frames, rounding, saturation, pipelining, hold and mid-flight reset.
module tb_dit_ifft_8;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [15:0] x [0:7][0:1];
  logic               out_valid;
  logic signed [15:0] y [0:7][0:1];

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [15:0] exp_q [$];

  dit_ifft_8 #(.DW(16), .FB(12)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .x        (x),
    .out_valid(out_valid),
    .y        (y)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_x();
    for (int k = 0; k < 8; k++) begin
      x[k][0] = '0;
      x[k][1] = '0;
    end
  endtask

  // Presents x for one edge, then advances to just after the edge where the result is due
  task automatic run_frame();
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    clear_x();
    repeat (3) cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    clear_x();
    #1;
    repeat (2) cycle();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (y[k][0] !== 16'sh0000 || y[k][1] !== 16'sh0000) begin
        tests_failed++;
        $display("FAIL reset_y k=%0d got=%h+%hj exp=0000+0000j", k, y[k][0], y[k][1]);
      end
    end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_impulse();
    clear_x();
    x[0][0]  = 16'sh1000;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    clear_x();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL impulse_early_valid edge=N+%0d got=%b exp=0", i, out_valid);
      end
      cycle();
    end
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL impulse_valid_at_n3 got=%b exp=1", out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (y[k][0] !== 16'sh0200 || y[k][1] !== 16'sh0000) begin
        tests_failed++;
        $display("FAIL impulse_y k=%0d got=%h+%hj exp=0200+0000j", k, y[k][0], y[k][1]);
      end
    end
    cycle();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL impulse_single_pulse got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_dc();
    logic [15:0] er;
    clear_x();
    for (int k = 0; k < 8; k++) x[k][0] = 16'sh1000;
    run_frame();
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL dc_valid got=%b exp=1", out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      er = (k == 0) ? 16'h1000 : 16'h0000;
      tests_run++;
      if (y[k][0] !== er || y[k][1] !== 16'h0000) begin
        tests_failed++;
        $display("FAIL dc_y k=%0d got=%h+%hj exp=%h+0000j", k, y[k][0], y[k][1], er);
      end
    end
  endtask

  task automatic test_tone();
    logic [15:0] er [8];
    logic [15:0] ei [8];
    er = '{16'h0200, 16'h016A, 16'h0000, 16'hFE96, 16'hFE00, 16'hFE96, 16'h0000, 16'h016A};
    ei = '{16'h0000, 16'h016A, 16'h0200, 16'h016A, 16'h0000, 16'hFE96, 16'hFE00, 16'hFE96};
    clear_x();
    x[1][0] = 16'sh1000;
    run_frame();
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL tone_valid got=%b exp=1", out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (y[k][0] !== er[k] || y[k][1] !== ei[k]) begin
        tests_failed++;
        $display("FAIL tone_y k=%0d got=%h+%hj exp=%h+%hj", k, y[k][0], y[k][1], er[k], ei[k]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [15:0] exp_pos;
    logic [15:0] exp_neg;
`ifdef IFFT_ROUND_EN
    exp_pos = 16'h0001;
    exp_neg = 16'h0000;
`else
    exp_pos = 16'h0000;
    exp_neg = 16'hFFFF;
`endif
    clear_x();
    x[0][0] = 16'sh0004;
    run_frame();
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (y[k][0] !== exp_pos || y[k][1] !== 16'h0000) begin
        tests_failed++;
        $display("FAIL round_pos k=%0d got=%h+%hj exp=%h+0000j", k, y[k][0], y[k][1], exp_pos);
      end
    end
    clear_x();
    x[0][0] = -16'sh0004;
    run_frame();
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (y[k][0] !== exp_neg || y[k][1] !== 16'h0000) begin
        tests_failed++;
        $display("FAIL round_neg k=%0d got=%h+%hj exp=%h+0000j", k, y[k][0], y[k][1], exp_neg);
      end
    end
  endtask

  // Full-scale frame that pushes y[1].re past +1.0 through the W^-1 butterfly
  task automatic test_saturation();
    clear_x();
    x[0][0] = 16'sh7FFF;
    x[4][0] = 16'sh8000;
    x[2][1] = 16'sh8000;
    x[6][1] = 16'sh7FFF;
    x[1][0] = 16'sh7FFF;  x[1][1] = 16'sh8000;
    x[5][0] = 16'sh8000;  x[5][1] = 16'sh7FFF;
    x[3][0] = 16'sh8000;  x[3][1] = 16'sh8000;
    x[7][0] = 16'sh7FFF;  x[7][1] = 16'sh7FFF;
    run_frame();
    tests_run++;
    if (y[1][0] !== 16'h7FFF) begin
      tests_failed++;
      $display("FAIL sat_y1_re got=%h exp=7fff", y[1][0]);
    end
    tests_run++;
    if (y[5][0] !== 16'hE580) begin
      tests_failed++;
      $display("FAIL sat_y5_re got=%h exp=e580", y[5][0]);
    end
  endtask

  task automatic test_back_to_back();
    int n_valid = 0;
    int first   = -1;
    int last    = -1;
    logic [15:0] e0;
    logic [15:0] e1;
    exp_q.delete();
    clear_x();
    x[0][0]  = 16'sh1000;
    in_valid = 1'b1;
    exp_q.push_back(16'h0200); exp_q.push_back(16'h0200);
    cycle();
    clear_x();
    for (int k = 0; k < 8; k++) x[k][0] = 16'sh1000;
    exp_q.push_back(16'h1000); exp_q.push_back(16'h0000);
    cycle();
    clear_x();
    x[1][0] = 16'sh1000;
    exp_q.push_back(16'h0200); exp_q.push_back(16'h016A);
    cycle();
    in_valid = 1'b0;
    clear_x();
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) begin
        n_valid++;
        if (first < 0) first = i;
        last = i;
        tests_run++;
        if (exp_q.size() < 2) begin
          tests_failed++;
          $display("FAIL b2b_extra_frame cycle=%0d got=valid exp=no_more_frames", i);
        end else begin
          e0 = exp_q.pop_front();
          e1 = exp_q.pop_front();
          if (y[0][0] !== e0 || y[1][0] !== e1) begin
            tests_failed++;
            $display("FAIL b2b_order cycle=%0d got=%h,%h exp=%h,%h", i, y[0][0], y[1][0], e0, e1);
          end
        end
      end
      cycle();
    end
    tests_run++;
    if (n_valid != 3 || (last - first) != 2) begin
      tests_failed++;
      $display("FAIL b2b_valid_run got=%0d_cycles_span_%0d exp=3_cycles_span_2", n_valid, last - first);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_missing_frames got=%0d_left exp=0", exp_q.size());
    end
  endtask

  // y must keep the last frame (tone) while in_valid stays low and x carries junk
  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) begin
        x[k][0] = 16'($urandom);
        x[k][1] = 16'($urandom);
      end
      cycle();
      tests_run++;
      if (out_valid !== 1'b0 || y[1][0] !== 16'h016A || y[2][1] !== 16'h0200) begin
        tests_failed++;
        $display("FAIL hold cycle=%0d got=v%b,%h,%h exp=v0,016a,0200", i, out_valid, y[1][0], y[2][1]);
      end
    end
    clear_x();
  endtask

  task automatic test_reset_midflight();
    clear_x();
    x[0][0]  = 16'sh1000;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    clear_x();
    cycle();
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_valid got=%b exp=0", out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (y[k][0] !== 16'sh0000 || y[k][1] !== 16'sh0000) begin
        tests_failed++;
        $display("FAIL midreset_y k=%0d got=%h+%hj exp=0000+0000j", k, y[k][0], y[k][1]);
      end
    end
    cycle();
    cycle();
    reset    = 1'b0;
    x[1][0]  = 16'sh1000;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    clear_x();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_stray_valid edge=N+%0d got=%b exp=0", i, out_valid);
      end
      cycle();
    end
    tests_run++;
    if (out_valid !== 1'b1 || y[1][0] !== 16'h016A || y[2][1] !== 16'h0200) begin
      tests_failed++;
      $display("FAIL post_reset_accept got=v%b,%h,%h exp=v1,016a,0200", out_valid, y[1][0], y[2][1]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_tone();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_hold();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
